register_file: RTL and testbench

32-entry, 64-bit general-purpose register file for the single-cycle datapath. It supplies the A and B operands to the ALU bitwise and arithmetic units, including the 64-bit OR, and accepts the writeback result at the end of each cycle. Reads are combinational with write-through bypass. Register 31 (XZR) is hardwired to zero.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/register_file_if.sv | 25 ++
 rtl/register_file_register_n.sv | 29 ++
 rtl/register_file.sv | 54 +++++
 tb/tb_register_file.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, register-file types and XZR helper
package cpu_pkg;

  localparam int REGISTER_LENGTH = 64;
  localparam int NUM_REGS        = 32;
  localparam int ADDR_WIDTH      = 5;

  localparam logic [ADDR_WIDTH-1:0] XZR_INDEX = 5'd31;

  typedef logic [REGISTER_LENGTH-1:0] reg_word_t;
  typedef logic [ADDR_WIDTH-1:0]      reg_addr_t;

  // True when the index names the hardwired zero register.
  function automatic logic is_xzr(reg_addr_t idx);
    return idx == XZR_INDEX;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - writeback and dual read-port bundle of the register file
interface register_file_if;
  import cpu_pkg::*;

  logic      RegWrite_i;
  reg_addr_t WriteReg_i;
  reg_word_t WriteData_i;
  reg_addr_t ReadReg1_i;
  reg_addr_t ReadReg2_i;
  reg_word_t ReadData1_o;
  reg_word_t ReadData2_o;

  // Datapath side: drives writeback and read indices, consumes operands.
  modport master (
    output RegWrite_i, WriteReg_i, WriteData_i, ReadReg1_i, ReadReg2_i,
    input  ReadData1_o, ReadData2_o
  );

  // Register file side.
  modport slave (
    input  RegWrite_i, WriteReg_i, WriteData_i, ReadReg1_i, ReadReg2_i,
    output ReadData1_o, ReadData2_o
  );

endinterface

// File: rtl/register_file_register_n.sv
// rtl/register_file_register_n.sv - one architectural register with write enable
module register_N
  import cpu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      we_i,
  input  reg_word_t d_i,
  output reg_word_t q_o
);

  reg_word_t data_q;
  reg_word_t data_d;

  // Load new data only when this register is the selected writeback target.
  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  // Storage flops; reset clears immediately, independent of the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x64 register file, two combinational read ports with write-through bypass
module register_file
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  register_file_if.slave  rf
);

  // Index 31 has no storage, so the decoder only produces enables 0..30.
  logic [NUM_REGS-2:0] we_dec;
  reg_word_t           regs [NUM_REGS];
  reg_word_t           mux1;
  reg_word_t           mux2;
  reg_word_t           byp1;
  reg_word_t           byp2;

  // Write decode gated by RegWrite; a write aimed at XZR matches no enable.
  always_comb begin
    we_dec = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      we_dec[i] = rf.RegWrite_i && (rf.WriteReg_i == reg_addr_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_regs
    register_N u_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (we_dec[g]),
      .d_i   (rf.WriteData_i),
      .q_o   (regs[g])
    );
  end

  assign regs[NUM_REGS-1] = '0;

  // Operand A: stored value, then same-cycle bypass, then zero force for XZR.
  always_comb begin
    mux1 = regs[rf.ReadReg1_i];
    byp1 = mux1;
    if (rf.RegWrite_i && (rf.WriteReg_i == rf.ReadReg1_i)) byp1 = rf.WriteData_i;
    rf.ReadData1_o = is_xzr(rf.ReadReg1_i) ? '0 : byp1;
  end

  // Operand B: same structure as operand A, fully independent.
  always_comb begin
    mux2 = regs[rf.ReadReg2_i];
    byp2 = mux2;
    if (rf.RegWrite_i && (rf.WriteReg_i == rf.ReadReg2_i)) byp2 = rf.WriteData_i;
    rf.ReadData2_o = is_xzr(rf.ReadReg2_i) ? '0 : byp2;
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
  import cpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      we;
  reg_addr_t wa;
  reg_word_t wd;
  reg_addr_t r1;
  reg_addr_t r2;

  reg_word_t model [NUM_REGS-1];
  reg_word_t exp1_q [$];
  reg_word_t exp2_q [$];
  reg_word_t e1;
  reg_word_t e2;
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  register_file_if rf ();

  assign rf.RegWrite_i  = we;
  assign rf.WriteReg_i  = wa;
  assign rf.WriteData_i = wd;
  assign rf.ReadReg1_i  = r1;
  assign rf.ReadReg2_i  = r2;

  register_file dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf    (rf)
  );

  function automatic reg_word_t exp_read(reg_addr_t r);
    if (r == 5'd31) return '0;
    if (we && wa == r) return wd;
    return model[r];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS - 1; i++) model[i] = '0;
  endtask

  task automatic drive(logic w, reg_addr_t a, reg_word_t d, reg_addr_t ra, reg_addr_t rb);
    we = w; wa = a; wd = d; r1 = ra; r2 = rb;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (!rst && we && wa != 5'd31) model[wa] = wd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd5);
    @(negedge clk);
    exp1_q.push_back(64'd0); exp2_q.push_back(64'd0);
    #1;
    e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
    if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL reset_state p1 got %h exp %h", rf.ReadData1_o, e1); end
    if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL reset_state p2 got %h exp %h", rf.ReadData2_o, e2); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd5);
    clock_edge();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5);
    exp1_q.push_back(64'hDEAD_BEEF_0000_0001); exp2_q.push_back(exp_read(r2));
    #1;
    e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
    if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL x5_loaded p1 got %h exp %h", rf.ReadData1_o, e1); end
    if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL x5_loaded p2 got %h exp %h", rf.ReadData2_o, e2); end
    #1;
    rst = 1'b1;
    clear_model();
    exp1_q.push_back(64'd0); exp2_q.push_back(exp_read(r2));
    #1;
    e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
    if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL async_reset p1 got %h exp %h", rf.ReadData1_o, e1); end
    if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL async_reset p2 got %h exp %h", rf.ReadData2_o, e2); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      drive(1'b1, reg_addr_t'(i), 64'h0101_0101_0101_0101 * 64'(i + 1), 5'd0, 5'd0);
      clock_edge();
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      drive(1'b0, 5'd0, '0, reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i));
      exp1_q.push_back(i == 31 ? 64'd0 : 64'h0101_0101_0101_0101 * 64'(i + 1));
      exp2_q.push_back(i == 0 ? 64'd0 : 64'h0101_0101_0101_0101 * 64'(NUM_REGS - i));
      #1;
      e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
      if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL read_all[%0d] p1 got %h exp %h", i, rf.ReadData1_o, e1); end
      if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL read_all[%0d] p2 got %h exp %h", i, rf.ReadData2_o, e2); end
      clock_edge();
    end
  endtask

  task automatic test_xzr();
    for (int c = 0; c < 2; c++) begin
      drive(c == 0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
      exp1_q.push_back(64'd0); exp2_q.push_back(64'd0);
      #1;
      e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
      if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL xzr[%0d] p1 got %h exp %h", c, rf.ReadData1_o, e1); end
      if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL xzr[%0d] p2 got %h exp %h", c, rf.ReadData2_o, e2); end
      clock_edge();
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
    clock_edge();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        drive(1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
        clock_edge();
      end
      drive(c != 2 && c != 3, 5'd7, 64'h2222, 5'd7, 5'd7);
      if (c == 3) we = 1'b0;
      exp1_q.push_back(c == 3 ? 64'h1111 : 64'h2222);
      exp2_q.push_back(exp_read(r2));
      #1;
      e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
      if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL bypass[%0d] p1 got %h exp %h", c, rf.ReadData1_o, e1); end
      if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL bypass[%0d] p2 got %h exp %h", c, rf.ReadData2_o, e2); end
      clock_edge();
    end
  endtask

  task automatic test_reset_vs_write();
    rst = 1'b1;
    clear_model();
    drive(1'b1, 5'd3, 64'hABCD, 5'd0, 5'd0);
    clock_edge();
    rst = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd3, 5'd3);
    exp1_q.push_back(64'd0); exp2_q.push_back(exp_read(r2));
    #1;
    e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
    if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL rst_vs_wr p1 got %h exp %h", rf.ReadData1_o, e1); end
    if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL rst_vs_wr p2 got %h exp %h", rf.ReadData2_o, e2); end
    drive(1'b1, 5'd3, 64'hABCD, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 5'd0, '0, 5'd3, 5'd3);
    exp1_q.push_back(64'hABCD); exp2_q.push_back(exp_read(r2));
    #1;
    e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
    if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL post_rst_wr p1 got %h exp %h", rf.ReadData1_o, e1); end
    if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL post_rst_wr p2 got %h exp %h", rf.ReadData2_o, e2); end
    clock_edge();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 31)),
            {$urandom, $urandom}, reg_addr_t'($urandom_range(0, 31)),
            reg_addr_t'($urandom_range(0, 31)));
      exp1_q.push_back(exp_read(r1)); exp2_q.push_back(exp_read(r2));
      #1;
      e1 = exp1_q.pop_front(); e2 = exp2_q.pop_front(); checks += 2;
      if (rf.ReadData1_o !== e1) begin errors++; $display("FAIL random[%0d] p1 r%0d got %h exp %h", n, r1, rf.ReadData1_o, e1); end
      if (rf.ReadData2_o !== e2) begin errors++; $display("FAIL random[%0d] p2 r%0d got %h exp %h", n, r2, rf.ReadData2_o, e2); end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_write_read_all();
    test_xzr();
    test_bypass();
    test_reset_vs_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
